sample_framer: RTL and testbench

SAMPLE_FRAMER -- requirements
Module: sample_framer

---
 rtl/sample_framer.sv | 152 +++++++++++++++
 tb/tb_sample_framer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_framer.sv
// Sliding-window framer: pops samples from a FWFT FIFO into a circular buffer
// and streams overlapping frames of FRAME_LEN words, HOP new words apart.
module sample_framer #(
   parameter int DATASIZE  = 16,
   parameter int FRAMEBITS = 8,
   parameter int HOP       = 128
) (
   input  logic                 rclk,
   input  logic                 rrst_n,
   input  logic [DATASIZE-1:0]  fifo_rdata,
   input  logic                 fifo_rempty,
   output logic                 fifo_rinc,
   input  logic                 flush,
   output logic [DATASIZE-1:0]  m_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic                 m_last,
   output logic [FRAMEBITS-1:0] m_index,
   output logic [15:0]          frame_count
);

   localparam int FRAME_LEN = 1 << FRAMEBITS;
   localparam int CW        = FRAMEBITS + 1;

   localparam logic [CW-1:0]        FILL_LAST = CW'(FRAME_LEN - 1);
   localparam logic [CW-1:0]        HOP_LAST  = CW'(HOP - 1);
   localparam logic [FRAMEBITS-1:0] IDX_LAST  = FRAMEBITS'(FRAME_LEN - 1);

   typedef enum logic [1:0] {
      S_FILL,
      S_EMIT,
      S_REFILL
   } state_e;

   state_e                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [FRAMEBITS-1:0]  wr_ptr_q, wr_ptr_d;
   logic [FRAMEBITS-1:0]  rd_idx_q, rd_idx_d;
   logic [DATASIZE-1:0]   m_data_q, m_data_d;
   logic                  m_valid_q, m_valid_d;
   logic                  m_last_q, m_last_d;
   logic [FRAMEBITS-1:0]  m_index_q, m_index_d;
   logic [15:0]           fc_q, fc_d;

   logic [DATASIZE-1:0]   mem_q [FRAME_LEN];

   logic                  pop;
   logic                  load;
   logic                  xfer;
   logic [FRAMEBITS-1:0]  rd_addr;
   logic [CW-1:0]         cnt_lim;

   // reset gating lives only on the strobe; state is already held in reset
   assign pop       = (state_q != S_EMIT) && !fifo_rempty && !flush;
   assign fifo_rinc = pop && rrst_n;
   assign xfer      = m_valid_q && m_ready;
   assign load      = (state_q == S_EMIT) && (!m_valid_q || m_ready);
   assign rd_addr   = wr_ptr_q + rd_idx_q;
   assign cnt_lim   = (state_q == S_FILL) ? FILL_LAST : HOP_LAST;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wr_ptr_d  = wr_ptr_q;
      rd_idx_d  = rd_idx_q;
      m_data_d  = m_data_q;
      m_valid_d = m_valid_q;
      m_last_d  = m_last_q;
      m_index_d = m_index_q;
      fc_d      = fc_q;
      if (flush) begin
         state_d   = S_FILL;
         cnt_d     = '0;
         rd_idx_d  = '0;
         m_valid_d = 1'b0;
      end else begin
         if (xfer) begin
            m_valid_d = 1'b0;
            if (m_last_q) begin
               fc_d = fc_q + 16'd1;
            end
         end
         unique case (state_q)
            S_FILL, S_REFILL: begin
               if (pop) begin
                  wr_ptr_d = wr_ptr_q + FRAMEBITS'(1);
                  if (cnt_q == cnt_lim) begin
                     state_d = S_EMIT;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end
            end
            S_EMIT: begin
               if (load) begin
                  m_data_d  = mem_q[rd_addr];
                  m_index_d = rd_idx_q;
                  m_last_d  = (rd_idx_q == IDX_LAST);
                  m_valid_d = 1'b1;
                  rd_idx_d  = rd_idx_q + FRAMEBITS'(1);
                  if (rd_idx_q == IDX_LAST) begin
                     state_d = S_REFILL;
                  end
               end
            end
            default: begin
               state_d = S_FILL;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         state_q   <= S_FILL;
         cnt_q     <= '0;
         wr_ptr_q  <= '0;
         rd_idx_q  <= '0;
         m_data_q  <= '0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
         m_index_q <= '0;
         fc_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_idx_q  <= rd_idx_d;
         m_data_q  <= m_data_d;
         m_valid_q <= m_valid_d;
         m_last_q  <= m_last_d;
         m_index_q <= m_index_d;
         fc_q      <= fc_d;
      end
   end

   // sample storage is deliberately left out of reset
   always_ff @(posedge rclk) begin
      if (pop) begin
         mem_q[wr_ptr_q] <= fifo_rdata;
      end
   end

   assign m_data      = m_data_q;
   assign m_valid     = m_valid_q;
   assign m_last      = m_last_q;
   assign m_index     = m_index_q;
   assign frame_count = fc_q;

endmodule

// File: tb/tb_sample_framer.sv
// Self-checking bench for sample_framer (FRAMEBITS=3, HOP=4): FIFO model,
// frame model from the popped word stream, directed and random phases.
module tb_sample_framer;

   localparam int DW   = 16;
   localparam int FB   = 3;
   localparam int HOP  = 4;
   localparam int FL   = 8;
   localparam int NSRC = 1024;

   logic          rclk = 1'b0;
   logic          rrst_n = 1'b0;
   logic          flush = 1'b0;
   logic          m_ready = 1'b1;
   logic          stall = 1'b0;
   logic          fifo_rempty;
   logic [DW-1:0] fifo_rdata;
   logic          fifo_rinc;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_last;
   logic [FB-1:0] m_index;
   logic [15:0]   frame_count;

   logic [DW-1:0] src [NSRC];
   int            pop_n = 0;
   int            cyc = 0;
   int            checks = 0;
   int            failures = 0;

   int            m_base, m_frame, m_idx, m_fc, e;
   int            first_vc = -1;
   int            first_vp = 0;
   bit            prev_hold = 1'b0;
   bit            prev_flush = 1'b0;
   logic [DW-1:0] acc [$];
   int            acc_cyc [$];
   int            n0;
   bit            ok;

   sample_framer #(
      .DATASIZE  (DW),
      .FRAMEBITS (FB),
      .HOP       (HOP)
   ) dut (
      .rclk        (rclk),
      .rrst_n      (rrst_n),
      .fifo_rdata  (fifo_rdata),
      .fifo_rempty (fifo_rempty),
      .fifo_rinc   (fifo_rinc),
      .flush       (flush),
      .m_data      (m_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_last      (m_last),
      .m_index     (m_index),
      .frame_count (frame_count)
   );

   always #5 rclk = ~rclk;

   // upstream FWFT FIFO: never runs dry, only stalls on demand
   assign fifo_rempty = stall;
   assign fifo_rdata  = src[10'(pop_n)];

   always @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         pop_n <= 0;
         cyc   <= 0;
      end else begin
         cyc <= cyc + 1;
         if (fifo_rinc) pop_n <= pop_n + 1;
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // frame j after a restart is words [base + j*HOP, +FL) of the pop stream
   always @(negedge rclk) begin
      if (!rrst_n) begin
         m_base = 0;
         m_frame = 0;
         m_idx = 0;
         m_fc = 0;
         first_vc = -1;
         prev_hold = 1'b0;
         prev_flush = 1'b0;
         acc.delete();
         acc_cyc.delete();
      end else begin
         chk("frame_count", int'(frame_count), m_fc);
         if (fifo_rinc) chk("rinc_when_empty", int'(fifo_rempty), 0);
         if (prev_flush) chk("valid_after_flush", int'(m_valid), 0);
         if (prev_hold) chk("valid_held", int'(m_valid), 1);
         if (m_valid) begin
            e = m_base + m_frame * HOP + m_idx;
            if (first_vc < 0) begin
               first_vc = cyc;
               first_vp = pop_n;
            end
            chk("word_popped", int'(e < pop_n), 1);
            chk("m_index", int'(m_index), m_idx);
            chk("m_last", int'(m_last), int'(m_idx == FL - 1));
            chk("m_data", int'(m_data), int'(src[10'(e)]));
         end
         prev_hold = m_valid && !m_ready && !flush;
         prev_flush = flush;
         if (flush) begin
            m_base = pop_n;
            m_frame = 0;
            m_idx = 0;
         end else if (m_valid && m_ready) begin
            acc.push_back(m_data);
            if (m_idx == 0) acc_cyc.push_back(cyc);
            if (m_idx == FL - 1) begin
               m_idx = 0;
               m_frame++;
               m_fc = (m_fc + 1) & 16'hFFFF;
            end else begin
               m_idx++;
            end
         end
      end
   end

   task automatic do_reset(input int base_val, input bit rnd);
      rrst_n = 1'b0;
      flush = 1'b0;
      m_ready = 1'b1;
      stall = 1'b0;
      for (int k = 0; k < NSRC; k++) begin
         src[k] = rnd ? DW'($urandom) : DW'(base_val + k);
      end
      repeat (2) @(posedge rclk);
      #1 rrst_n = 1'b1;
   endtask

   task automatic wait_idx(input int idx, input int fc, input int budget,
                           output bit hit);
      hit = 1'b0;
      for (int n = 0; n < budget && !hit; n++) begin
         @(posedge rclk);
         #1;
         if (m_valid && int'(m_index) == idx && int'(frame_count) == fc)
            hit = 1'b1;
      end
      if (!hit) chk("wait_idx_timeout", 0, 1);
   endtask

   task automatic wait_acc(input int n, input int budget);
      int t;
      t = 0;
      while (acc.size() < n && t < budget) begin
         @(posedge rclk);
         #1;
         t++;
      end
      if (acc.size() < n) chk("wait_acc_timeout", acc.size(), n);
   endtask

   task automatic wait_first(input int budget);
      int t;
      t = 0;
      while (first_vc < 0 && t < budget) begin
         @(posedge rclk);
         #1;
         t++;
      end
      if (first_vc < 0) chk("first_valid_timeout", 0, 1);
   endtask

   initial begin
      // continuous supply, overlapping frames
      do_reset(1, 1'b0);
      wait_acc(24, 200);
      chk("a_first_valid_cyc", first_vc, 9);
      chk("a_pops_at_first", first_vp, 8);
      chk("a_f1_w0", int'(acc[0]), 1);
      chk("a_f1_w7", int'(acc[7]), 8);
      chk("a_f2_w0", int'(acc[8]), 5);
      chk("a_f2_w7", int'(acc[15]), 12);
      chk("a_f3_w0", int'(acc[16]), 9);
      chk("a_f3_w7", int'(acc[23]), 16);
      chk("a_frame_count", int'(frame_count), 3);
      chk("a_start_cyc", acc_cyc[0], 9);
      chk("a_period_1", acc_cyc[1] - acc_cyc[0], 12);
      chk("a_period_2", acc_cyc[2] - acc_cyc[1], 12);

      // back-pressure on word 2
      do_reset(1, 1'b0);
      wait_idx(2, 0, 50, ok);
      m_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge rclk);
         #1;
         chk("b_hold_data", int'(m_data), 3);
         chk("b_hold_index", int'(m_index), 2);
      end
      m_ready = 1'b1;
      wait_acc(8, 50);
      for (int i = 0; i < FL; i++) chk("b_frame", int'(acc[i]), i + 1);

      // FIFO empty every other cycle during FILL
      do_reset(1, 1'b0);
      while (first_vc < 0 && cyc < 40) begin
         @(posedge rclk);
         #1;
         if (first_vc < 0) stall = ~stall;
      end
      stall = 1'b0;
      chk("c_first_valid_cyc", first_vc, 16);
      chk("c_pops_at_first", first_vp, 8);
      wait_acc(8, 50);
      for (int i = 0; i < FL; i++) chk("c_frame", int'(acc[i]), i + 1);

      // flush at word 3 of frame 2
      do_reset(1, 1'b0);
      wait_idx(3, 1, 100, ok);
      n0 = acc.size();
      flush = 1'b1;
      @(posedge rclk);
      #1 flush = 1'b0;
      chk("d_valid_after_flush", int'(m_valid), 0);
      chk("d_frame_count", int'(frame_count), 1);
      chk("d_pops_at_flush", pop_n, 12);
      wait_acc(n0 + 8, 100);
      for (int i = 0; i < FL; i++) chk("d_frame", int'(acc[n0 + i]), 13 + i);

      // asynchronous reset mid-EMIT
      do_reset(1, 1'b0);
      wait_idx(4, 1, 100, ok);
      #2 rrst_n = 1'b0;
      #1;
      chk("e_valid", int'(m_valid), 0);
      chk("e_data", int'(m_data), 0);
      chk("e_last", int'(m_last), 0);
      chk("e_index", int'(m_index), 0);
      chk("e_frame_count", int'(frame_count), 0);
      chk("e_rinc", int'(fifo_rinc), 0);
      for (int k = 0; k < NSRC; k++) src[k] = DW'(100 + k);
      repeat (2) @(posedge rclk);
      #1 rrst_n = 1'b1;
      wait_first(40);
      chk("e_first_valid_cyc", first_vc, 9);
      chk("e_pops_at_first", first_vp, 8);
      wait_acc(8, 50);
      chk("e_w0", int'(acc[0]), 100);
      chk("e_w7", int'(acc[7]), 107);

      // random data, back-pressure, stalls and flushes
      do_reset(0, 1'b1);
      for (int n = 0; n < 800; n++) begin
         @(posedge rclk);
         #1;
         m_ready = ($urandom % 4) != 0;
         stall = ($urandom % 4) == 0;
         flush = flush ? 1'b0 : (($urandom % 80) == 0);
      end
      m_ready = 1'b1;
      stall = 1'b0;
      flush = 1'b0;
      repeat (40) @(posedge rclk);
      #1;
      chk("f_progress", int'(acc.size() > 100), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
